// File: rtl/kbd_scan_ctrl.sv
// rtl/kbd_scan_ctrl.sv - PS/2 scan-code decoder: pops receiver FIFO, tracks make/break/repeat.
// Optional E0 extended-key support: define KBD_SCAN_CTRL_EXT_EN.
module kbd_scan_ctrl (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] data,
    input  logic       ready,
    input  logic       overflow,
    input  logic       clr_ovf,
    output logic       nextdata_n,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_valid,
    output logic       press_pulse,
    output logic [7:0] key_count,
    output logic       ovf_flag
);

    typedef enum logic [1:0] {S_IDLE, S_POP, S_SETTLE} state_t;

    state_t     state;
    logic [7:0] byte_q;
    logic       brk_pending;
    logic       cur_ext;
    logic       same_key;

`ifdef KBD_SCAN_CTRL_EXT_EN
    logic ext_pending;
    logic key_ext_q;
    assign cur_ext = ext_pending;
    assign key_ext = key_ext_q;
`else
    assign cur_ext = 1'b0;
    assign key_ext = 1'b0;
`endif

    assign same_key = (byte_q == key_code) && (cur_ext == key_ext);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state       <= S_IDLE;
            nextdata_n  <= 1'b1;
            byte_q      <= 8'h00;
            key_code    <= 8'h00;
            key_valid   <= 1'b0;
            press_pulse <= 1'b0;
            key_count   <= 8'h00;
            brk_pending <= 1'b0;
`ifdef KBD_SCAN_CTRL_EXT_EN
            ext_pending <= 1'b0;
            key_ext_q   <= 1'b0;
`endif
        end else begin
            press_pulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ready) begin
                        byte_q     <= data;
                        state      <= S_POP;
                        nextdata_n <= 1'b0;
                    end
                end
                S_POP: begin
                    nextdata_n <= 1'b1;
                    state      <= S_SETTLE;
                    if (byte_q == 8'hF0) begin
                        brk_pending <= 1'b1;
                    end else if (byte_q == 8'hE0) begin
`ifdef KBD_SCAN_CTRL_EXT_EN
                        ext_pending <= 1'b1;
`endif
                    end else begin
                        if (!brk_pending) begin
                            // A make matching the held key is typematic repeat.
                            if (!(key_valid && same_key)) begin
                                key_code    <= byte_q;
`ifdef KBD_SCAN_CTRL_EXT_EN
                                key_ext_q   <= ext_pending;
`endif
                                key_valid   <= 1'b1;
                                press_pulse <= 1'b1;
                                key_count   <= key_count + 8'd1;
                            end
                        end else if (same_key) begin
                            key_valid <= 1'b0;
                        end
                        brk_pending <= 1'b0;
`ifdef KBD_SCAN_CTRL_EXT_EN
                        ext_pending <= 1'b0;
`endif
                    end
                end
                default: begin
                    // SETTLE lets the receiver's read pointer advance before ready is re-tested.
                    nextdata_n <= 1'b1;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            ovf_flag <= 1'b0;
        else if (overflow)
            ovf_flag <= 1'b1;
        else if (clr_ovf)
            ovf_flag <= 1'b0;
    end

endmodule

// File: tb/tb_kbd_scan_ctrl.sv
// tb/tb_kbd_scan_ctrl.sv - directed table-driven bench for kbd_scan_ctrl.
module tb_kbd_scan_ctrl;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic [7:0] data = 8'h00;
    logic       ready = 1'b0;
    logic       overflow = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       nextdata_n;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_valid;
    logic       press_pulse;
    logic [7:0] key_count;
    logic       ovf_flag;

    int n_tests = 0;
    int n_fail  = 0;
    int nl_cnt  = 0;
    int pp_cnt  = 0;

    kbd_scan_ctrl dut (
        .clk(clk), .clrn(clrn), .data(data), .ready(ready), .overflow(overflow),
        .clr_ovf(clr_ovf), .nextdata_n(nextdata_n), .key_code(key_code), .key_ext(key_ext),
        .key_valid(key_valid), .press_pulse(press_pulse), .key_count(key_count),
        .ovf_flag(ovf_flag)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!nextdata_n) nl_cnt++;
        if (press_pulse) pp_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    typedef struct {
        logic       rst;
        logic [7:0] b;
        logic [7:0] code;
        logic       ext;
        logic       valid;
        logic [7:0] cnt;
        int         pulses;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [7:0] b, input logic [7:0] c,
                       input logic e, input logic vl, input logic [7:0] n, input int p);
        vecs.push_back('{r, b, c, e, vl, n, p});
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        clrn = 1'b0;
        ready = 1'b0;
        overflow = 1'b0;
        clr_ovf = 1'b0;
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        data = b;
        ready = 1'b1;
        while (nextdata_n && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (nextdata_n) begin
            n_tests++;
            n_fail++;
            $display("FAIL pop_timeout act=no_pop exp=pop byte=%0h", b);
        end
        ready = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    int nl0, pp0;

    initial begin
        // Reset-state check.
        do_reset();
        chk("rst_nextdata_n", nextdata_n, 1);
        chk("rst_key_code", key_code, 8'h00);
        chk("rst_key_ext", key_ext, 0);
        chk("rst_key_valid", key_valid, 0);
        chk("rst_press_pulse", press_pulse, 0);
        chk("rst_key_count", key_count, 8'h00);
        chk("rst_ovf_flag", ovf_flag, 0);

        // press, release
        add(1, 8'h1C, 8'h1C, 0, 1, 8'd1, 1);
        add(0, 8'hF0, 8'h1C, 0, 1, 8'd1, 0);
        add(0, 8'h1C, 8'h1C, 0, 0, 8'd1, 0);
        // auto-repeat then release
        add(1, 8'h1B, 8'h1B, 0, 1, 8'd1, 1);
        add(0, 8'h1B, 8'h1B, 0, 1, 8'd1, 0);
        add(0, 8'h1B, 8'h1B, 0, 1, 8'd1, 0);
        add(0, 8'hF0, 8'h1B, 0, 1, 8'd1, 0);
        add(0, 8'h1B, 8'h1B, 0, 0, 8'd1, 0);
        // foreign break, then F0 F0 break of the held key
        add(1, 8'h1C, 8'h1C, 0, 1, 8'd1, 1);
        add(0, 8'h1B, 8'h1B, 0, 1, 8'd2, 1);
        add(0, 8'hF0, 8'h1B, 0, 1, 8'd2, 0);
        add(0, 8'h1C, 8'h1B, 0, 1, 8'd2, 0);
        add(0, 8'hF0, 8'h1B, 0, 1, 8'd2, 0);
        add(0, 8'hF0, 8'h1B, 0, 1, 8'd2, 0);
        add(0, 8'h1B, 8'h1B, 0, 0, 8'd2, 0);
`ifdef KBD_SCAN_CTRL_EXT_EN
        add(1, 8'hE0, 8'h00, 0, 0, 8'd0, 0);
        add(0, 8'h75, 8'h75, 1, 1, 8'd1, 1);
        add(0, 8'h75, 8'h75, 0, 1, 8'd2, 1);
        add(0, 8'hE0, 8'h75, 0, 1, 8'd2, 0);
        add(0, 8'h75, 8'h75, 1, 1, 8'd3, 1);
        add(0, 8'hF0, 8'h75, 1, 1, 8'd3, 0);
        add(0, 8'hE0, 8'h75, 1, 1, 8'd3, 0);
        add(0, 8'h75, 8'h75, 1, 0, 8'd3, 0);
`else
        add(1, 8'hE0, 8'h00, 0, 0, 8'd0, 0);
        add(0, 8'h75, 8'h75, 0, 1, 8'd1, 1);
        add(0, 8'h75, 8'h75, 0, 1, 8'd1, 0);
        add(0, 8'hE0, 8'h75, 0, 1, 8'd1, 0);
        add(0, 8'h75, 8'h75, 0, 1, 8'd1, 0);
        add(0, 8'hF0, 8'h75, 0, 1, 8'd1, 0);
        add(0, 8'hE0, 8'h75, 0, 1, 8'd1, 0);
        add(0, 8'h75, 8'h75, 0, 0, 8'd1, 0);
`endif

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            nl0 = nl_cnt;
            pp0 = pp_cnt;
            send(vecs[i].b);
            chk($sformatf("v%0d_key_code", i), key_code, vecs[i].code);
            chk($sformatf("v%0d_key_ext", i), key_ext, vecs[i].ext);
            chk($sformatf("v%0d_key_valid", i), key_valid, vecs[i].valid);
            chk($sformatf("v%0d_key_count", i), key_count, vecs[i].cnt);
            chk($sformatf("v%0d_press_pulses", i), pp_cnt - pp0, vecs[i].pulses);
            chk($sformatf("v%0d_pop_cycles", i), nl_cnt - nl0, 1);
        end

        // ready held high: one pop every 3 cycles, repeats of 1B count once.
        do_reset();
        nl0 = nl_cnt;
        pp0 = pp_cnt;
        data = 8'h1B;
        ready = 1'b1;
        repeat (12) @(negedge clk);
        ready = 1'b0;
        chk("burst_pops", nl_cnt - nl0, 4);
        chk("burst_pulses", pp_cnt - pp0, 1);
        repeat (2) @(negedge clk);
        chk("burst_key_count", key_count, 8'd1);

        // key_count wraps 255 -> 0.
        do_reset();
        for (int i = 0; i < 256; i++) send((i % 2 == 1) ? 8'h1C : 8'h1B);
        chk("wrap_key_count", key_count, 8'h00);
        chk("wrap_key_code", key_code, 8'h1C);
        chk("wrap_key_valid", key_valid, 1);

        // Overflow: set wins over clear, sticky, then clear.
        overflow = 1'b1;
        clr_ovf = 1'b1;
        @(negedge clk);
        overflow = 1'b0;
        clr_ovf = 1'b0;
        chk("ovf_set_wins", ovf_flag, 1);
        repeat (2) @(negedge clk);
        chk("ovf_sticky", ovf_flag, 1);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        chk("ovf_cleared", ovf_flag, 0);
        overflow = 1'b1;
        @(negedge clk);
        overflow = 1'b0;

        // Reset asserted mid-POP: byte is abandoned and re-read afterwards.
        data = 8'h1B;
        ready = 1'b1;
        begin
            int n;
            n = 0;
            while (nextdata_n && n < 10) begin
                @(negedge clk);
                n++;
            end
        end
        chk("midpop_in_pop", nextdata_n, 0);
        clrn = 1'b0;
        #1;
        chk("midpop_nextdata_n", nextdata_n, 1);
        chk("midpop_key_code", key_code, 8'h00);
        chk("midpop_key_valid", key_valid, 0);
        chk("midpop_key_count", key_count, 8'h00);
        chk("midpop_press_pulse", press_pulse, 0);
        chk("midpop_ovf_flag", ovf_flag, 0);
        chk("midpop_key_ext", key_ext, 0);
        @(negedge clk);
        clrn = 1'b1;
        nl0 = nl_cnt;
        send(8'h1B);
        chk("reread_pops", nl_cnt - nl0, 1);
        chk("reread_key_code", key_code, 8'h1B);
        chk("reread_key_valid", key_valid, 1);
        chk("reread_key_count", key_count, 8'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
